// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage buffer.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 160;
    localparam int unsigned CTRL_W_DEF = 21;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating 32-bit stall-cycle counter for the pipeline stage buffer.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] stall_cnt
);

    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall && (cnt != '1)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign stall_cnt = cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages; in_ready is registered.
// Optional stall counter port enabled by PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    buf_state_t        state;
    buf_state_t        state_nx;
    logic              in_ready_q;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_fire;
    logic              out_fire;
    logic              load_head_in;
    logic              load_head_skid;
    logic              load_skid;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = (state != EMPTY) & out_ready;

    always_comb begin
        state_nx       = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nx     = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_head_in = 1'b1;
                end else if (in_fire) begin
                    state_nx  = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nx       = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
        // Flush overrides every transfer decided above.
        if (flush) begin
            state_nx       = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_head_in) begin
                head_data <= in_data;
                head_ctrl <= in_ctrl;
            end else if (load_head_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = head_data;
    // Bubbles must never carry live control bits downstream.
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign occupancy = 2'(state);

`ifdef PIPE_STAGE_PERF_CNT_EN
    pipe_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .stall     (out_valid & ~out_ready),
        .stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: streaming, backpressure, flush, reset, bubble.
module tb_pipe_stage_buf;

    localparam int unsigned DATA_W = 160;
    localparam int unsigned CTRL_W = 21;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    pipe_stage_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned         n_chk = 0;
    int unsigned         n_bad = 0;
    int unsigned         n_out = 0;
    int unsigned         n_mark;
    logic [191:0]        sbq[$];
    logic [191:0]        exp_beat;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: handshakes are sampled on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst || flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 192'(sbq.size() != 0), 192'd1);
                end else begin
                    exp_beat = sbq.pop_front();
                    chk("out_beat", 192'({out_ctrl, out_data}), exp_beat);
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(192'({in_ctrl, in_data}));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] val);
        in_valid = v;
        in_data  = DATA_W'(val);
        in_ctrl  = CTRL_W'(val);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 192'(out_valid), 192'd0);
        chk("rst_occupancy", 192'(occupancy), 192'd0);
        chk("rst_out_ctrl",  192'(out_ctrl),  192'd0);
        chk("rst_out_data",  192'(out_data),  192'd0);
        chk("rst_in_ready",  192'(in_ready),  192'd1);

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i));
            tick();
            chk("stream_data", 192'(out_data), 192'(i));
            chk("stream_occ",  192'(occupancy), 192'd1);
            chk("stream_rdy",  192'(in_ready),  192'd1);
        end
        drive(1'b0, 32'h0);
        tick();
        chk("stream_empty", 192'(occupancy), 192'd0);
        chk("stream_drain", 192'(sbq.size()), 192'd0);
        chk("stream_count", 192'(n_out), 192'd5);

        // Backpressure: A and B fill the buffer, C waits.
        n_mark = n_out;
        out_ready = 1'b0;
        drive(1'b1, 32'hA); tick();
        drive(1'b1, 32'hB); tick();
        chk("bp_occ2",  192'(occupancy), 192'd2);
        chk("bp_rdy0",  192'(in_ready),  192'd0);
        drive(1'b1, 32'hC); tick();
        chk("bp_hold_occ",  192'(occupancy), 192'd2);
        chk("bp_hold_rdy",  192'(in_ready),  192'd0);
        chk("bp_hold_data", 192'(out_data),  192'hA);
        chk("bp_hold_ctrl", 192'(out_ctrl),  192'hA);
        out_ready = 1'b1;
        tick();
        tick();
        drive(1'b0, 32'h0);
        tick();
        chk("bp_count", 192'(n_out - n_mark), 192'd3);
        chk("bp_drain", 192'(sbq.size()), 192'd0);
        chk("bp_empty", 192'(occupancy), 192'd0);

        // Flush while FULL with a beat offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h11); tick();
        drive(1'b1, 32'h12); tick();
        chk("fl_pre_occ", 192'(occupancy), 192'd2);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'hDEAD);
        n_mark = n_out;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("fl_occ",   192'(occupancy), 192'd0);
        chk("fl_valid", 192'(out_valid), 192'd0);
        chk("fl_ctrl",  192'(out_ctrl),  192'd0);
        chk("fl_rdy",   192'(in_ready),  192'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("fl_no_emit", 192'(n_out - n_mark), 192'd0);

        // Reset while FULL with downstream ready.
        out_ready = 1'b0;
        drive(1'b1, 32'h21); tick();
        drive(1'b1, 32'h22); tick();
        chk("rs_pre_occ", 192'(occupancy), 192'd2);
        drive(1'b0, 32'h0);
        rst = 1'b1; out_ready = 1'b1;
        n_mark = n_out;
        tick();
        rst = 1'b0;
        chk("rs_valid", 192'(out_valid), 192'd0);
        chk("rs_occ",   192'(occupancy), 192'd0);
        chk("rs_rdy",   192'(in_ready),  192'd1);
        chk("rs_data",  192'(out_data),  192'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("rs_no_emit", 192'(n_out - n_mark), 192'd0);

        // Bubble: all-ones control pending but not yet buffered.
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_data  = '1;
        in_ctrl  = '1;
        tick();
        chk("bub_ctrl", 192'(out_ctrl), 192'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bub_live_ctrl", 192'(out_ctrl), 192'(CTRL_W'('1)));

`ifdef PIPE_STAGE_PERF_CNT_EN
        // Counter: reset, one buffered beat, then stalled cycles.
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b1, 32'h77); tick();
        drive(1'b0, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        chk("cnt_seven", 192'(stall_cnt), 192'd7);
        force dut.u_perf_cnt.cnt = 32'hFFFF_FFFE;
        #1;
        release dut.u_perf_cnt.cnt;
        for (int i = 0; i < 3; i++) tick();
        chk("cnt_sat", 192'(stall_cnt), 192'hFFFF_FFFF);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("cnt_flush_keep", 192'(stall_cnt), 192'hFFFF_FFFF);
`endif

        out_ready = 1'b1;
        tick();
        tick();
        chk("final_drain", 192'(sbq.size()), 192'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 160, meaning the datapath payload width (PC, RS1, RS2, immediate, instruction).
REQ-002 SHALL have parameter CTRL_W, default 21, meaning the control payload width (write dir, RegWrite, MemToReg, Branch, MemWrite, MemRead, ALUSrc, ALUCtrl, read dirs).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: drop all buffered entries (branch mispredict).
REQ-006 SHALL have port in_valid, input, 1 bit: upstream offers a beat.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have ports in_data, input, DATA_W bits, and in_ctrl, input, CTRL_W bits: the upstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the head entry.
REQ-011 SHALL have ports out_data, output, DATA_W bits, and out_ctrl, output, CTRL_W bits: the head payload.
REQ-012 SHALL have port occupancy, output, 2 bits: the entry count, 0..2.

Function
REQ-013 SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL.
- Transfer in: in_valid and in_ready.
- Transfer out: out_valid and out_ready.
REQ-014 SHALL have a latency of 1 cycle: a beat accepted in cycle N is visible on out_* in cycle N+1 when the block was EMPTY.
REQ-015 SHALL drive in_ready from a register (no combinational path from out_ready); in_ready=1 exactly when the state is not FULL.
REQ-016 SHALL apply these transitions:
- EMPTY+in -> ONE.
- ONE+in without out -> FULL.
- ONE+in+out -> ONE.
- ONE+out -> EMPTY.
- FULL+out -> ONE; in is impossible in FULL.
- Otherwise the state holds.
REQ-017 SHALL preserve order: the skid entry moves to the head when the head is consumed in FULL.
REQ-018 SHALL, when out_valid=0, drive out_ctrl to all-zero, so a bubble never asserts RegWrite, MemWrite or Branch; out_data is don't-care in that case.
REQ-019 SHALL hold out_data and out_ctrl stable while out_valid=1 and out_ready=0.
REQ-020 SHALL give flush priority over every transfer: next state is EMPTY, the in_* beat of that cycle is discarded, and out_ready in that cycle has no effect.
REQ-021 SHALL track occupancy exactly as the state (EMPTY=0, ONE=1, FULL=2), registered.

Reset
REQ-022 SHALL, with rst high at a clock edge, give these values:
- state EMPTY.
- out_valid=0.
- out_ctrl=0.
- out_data=0.
- occupancy=0.
- in_ready=1 from the next cycle.
REQ-023 SHALL give rst priority over flush and all handshakes; reset mid-transfer drops buffered entries without emitting them.

Configuration
REQ-024 SHALL, with macro PIPE_STAGE_PERF_CNT_EN defined, add output stall_cnt (32 bits), which counts cycles where out_valid=1 and out_ready=0.
- It saturates at 0xFFFFFFFF.
- rst clears it; flush does not.
REQ-025 SHALL, without PIPE_STAGE_PERF_CNT_EN, omit the stall_cnt port and its counter entirely.

Structure
REQ-026 SHALL place the state enum (EMPTY/ONE/FULL) and the default DATA_W/CTRL_W constants in shared package pipe_pkg.
REQ-027 SHALL implement the optional counter as sub-module pipe_perf_cnt, instantiated only under PIPE_STAGE_PERF_CNT_EN; everything else is flat.

Verification
REQ-028 SHALL cover streaming: out_ready=1 and beats 0x1..0x5 on consecutive cycles -> out_data 0x1..0x5 one cycle later, occupancy=1 steady, and in_ready never drops.
REQ-029 SHALL cover backpressure: out_ready=0 and beats A, B, C offered -> A and B accepted, occupancy=2, in_ready=0 and C held; then out_ready=1 -> A, B, C emitted in order.
REQ-030 SHALL cover flush while FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and the offered beat is never emitted.
REQ-031 SHALL cover reset while FULL with out_ready=1 -> no beat is emitted after the reset edge, and in_ready=1 one cycle later.
REQ-032 SHALL cover the bubble case: out_valid=0 with in_ctrl=all-ones stimulus pending -> out_ctrl reads 0.
REQ-033 SHALL cover the counter, with PIPE_STAGE_PERF_CNT_EN: 7 stalled cycles -> stall_cnt=7; a forced preload of 0xFFFFFFFE plus 3 stall cycles -> 0xFFFFFFFF.
